// File: rtl/return_address_stack.sv
// ---------------------------------------------------------------------------
// return_address_stack
//
// Circular return-address stack placed right after the fetch-bundle
// pre-decode stage. A jal pushes (branch address + 2), the instruction after
// the delay slot. A jr pops. The predicted jr target is the current top of
// stack. It is read combinationally from registered state, so fetch can
// sample it in the same cycle it sees the jr. When a push arrives while the
// stack is full, the oldest entry is overwritten.
//
// Optional feature (macro RAS_CHECKPOINT_EN):
//   i_checkpoint copies the post-update tos/count into snapshot registers.
//   i_restore reloads tos/count from that snapshot. Entries are not restored.
//   Restore has priority over flush, push and pop in the same cycle.
//   Without the macro, i_checkpoint and i_restore are accepted but ignored,
//   and no snapshot registers exist.
//
// Ports:
//   i_clk             clock; all state updates on the rising edge
//   i_reset           synchronous, active-high reset; overrides everything
//   i_valid           pre-decode outputs valid this cycle
//   i_jal_inst        jal detected in the current bundle
//   i_jr_inst         jr detected in the current bundle
//   i_branch_address  word address of the jal/jr instruction
//   i_flush           pipeline redirect; empties the stack
//   i_checkpoint      snapshot tos/count (RAS_CHECKPOINT_EN only)
//   i_restore         restore tos/count from the snapshot (RAS_CHECKPOINT_EN only)
//   o_ret_addr        top-of-stack entry, or 0 when the stack is empty
//   o_ret_valid       stack non-empty
//   o_empty           count == 0
//   o_full            count == DEPTH
//   o_count           number of valid entries
// ---------------------------------------------------------------------------
module return_address_stack #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DEPTH         = 8,
  parameter int PTR_WIDTH     = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic                     i_jal_inst,
  input  logic                     i_jr_inst,
  input  logic [ADDRESS_WIDTH-1:0] i_branch_address,
  input  logic                     i_flush,
  input  logic                     i_checkpoint,
  input  logic                     i_restore,
  output logic [ADDRESS_WIDTH-1:0] o_ret_addr,
  output logic                     o_ret_valid,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [PTR_WIDTH:0]       o_count
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1);

  // Return address is the instruction after the delay slot. The sum wraps
  // modulo 2^ADDRESS_WIDTH through the truncating return width.
  function automatic logic [ADDRESS_WIDTH-1:0] ret_value(
    input logic [ADDRESS_WIDTH-1:0] addr
  );
    return addr + ADDRESS_WIDTH'(2);
  endfunction

  logic [ADDRESS_WIDTH-1:0] entries [DEPTH];
  logic [PTR_WIDTH-1:0]     tos;
  logic [PTR_WIDTH:0]       count;

  logic [PTR_WIDTH-1:0]     tos_nxt;
  logic [PTR_WIDTH:0]       count_nxt;
  logic                     wr_en;
  logic [PTR_WIDTH-1:0]     wr_ptr;
  logic [ADDRESS_WIDTH-1:0] wr_data;

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;
  logic do_replace;

  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign do_push    = i_valid & i_jal_inst & ~i_jr_inst;
  assign do_pop     = i_valid & i_jr_inst & ~i_jal_inst;
  assign do_replace = i_valid & i_jal_inst & i_jr_inst;

`ifdef RAS_CHECKPOINT_EN
  logic [PTR_WIDTH-1:0] snap_tos;
  logic [PTR_WIDTH:0]   snap_count;
`else
  // Checkpoint/restore inputs are accepted but have no effect in this build.
  logic unused_ckpt;
  assign unused_ckpt = i_checkpoint ^ i_restore;
`endif

  // Next-state selection. The priority order from lowest to highest is:
  // push/pop/replace, then flush, then restore.
  always_comb begin
    tos_nxt   = tos;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_ptr    = tos;
    wr_data   = ret_value(i_branch_address);

    // A jal+jr pair on an empty stack has no top to replace, so it acts
    // as a plain push.
    if (do_push || (do_replace && empty)) begin
      tos_nxt   = tos + PTR_ONE;
      count_nxt = full ? count : count + CNT_ONE;
      wr_en     = 1'b1;
      wr_ptr    = tos + PTR_ONE;
    end else if (do_replace) begin
      wr_en     = 1'b1;
      wr_ptr    = tos;
    end else if (do_pop && !empty) begin
      tos_nxt   = tos - PTR_ONE;
      count_nxt = count - CNT_ONE;
    end

    // Flush leaves the entry contents stale. The write is dropped so that
    // a jal arriving in the flush cycle does not leak into the stack.
    if (i_flush) begin
      tos_nxt   = '0;
      count_nxt = '0;
      wr_en     = 1'b0;
    end

`ifdef RAS_CHECKPOINT_EN
    if (i_restore) begin
      tos_nxt   = snap_tos;
      count_nxt = snap_count;
      wr_en     = 1'b0;
    end
`endif
  end

  // Stack state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tos   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      tos   <= tos_nxt;
      count <= count_nxt;
      if (wr_en) begin
        entries[wr_ptr] <= wr_data;
      end
    end
  end

`ifdef RAS_CHECKPOINT_EN
  // The snapshot captures the post-update values. A checkpoint issued
  // together with a restore therefore re-captures the restored pointer
  // and count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      snap_tos   <= '0;
      snap_count <= '0;
    end else if (i_checkpoint) begin
      snap_tos   <= tos_nxt;
      snap_count <= count_nxt;
    end
  end
`endif

  // Outputs come from registered state only. The address is forced to 0
  // when empty so that an underflowing jr presents a clean, unpredicted
  // target.
  assign o_ret_valid = ~empty;
  assign o_ret_addr  = empty ? '0 : entries[tos];
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_count     = count;

endmodule

// File: tb/tb_return_address_stack.sv
// ---------------------------------------------------------------------------
// tb_return_address_stack
//
// Scoreboard bench for return_address_stack. The driver issues one
// stimulus per cycle. For that cycle it pushes the expected outputs, taken
// from a bounded-queue reference model of the stack contents. A monitor on
// the falling edge pops each expectation and compares it with the DUT
// outputs. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_return_address_stack;
  localparam int AW    = 22;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          valid_in = 1'b0;
  logic          jal_in = 1'b0;
  logic          jr_in = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          flush_in = 1'b0;
  logic          ckpt_in = 1'b0;
  logic          restore_in = 1'b0;
  logic [AW-1:0] ret_addr;
  logic          ret_valid;
  logic          empty;
  logic          full;
  logic [PW:0]   count;

  always #5 clk = ~clk;

  return_address_stack #(
    .ADDRESS_WIDTH(AW),
    .DEPTH(DEPTH),
    .PTR_WIDTH(PW)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_in),
    .i_valid(valid_in),
    .i_jal_inst(jal_in),
    .i_jr_inst(jr_in),
    .i_branch_address(addr_in),
    .i_flush(flush_in),
    .i_checkpoint(ckpt_in),
    .i_restore(restore_in),
    .o_ret_addr(ret_addr),
    .o_ret_valid(ret_valid),
    .o_empty(empty),
    .o_full(full),
    .o_count(count)
  );

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic [PW:0]   cnt;
    logic          emp;
    logic          ful;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] model_q[$];   // stack contents, oldest first, newest at the back
  logic [AW-1:0] snap_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares each cycle's outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ret_valid", 32'(ret_valid), 32'(e.rv));
        check("ret_addr",  32'(ret_addr),  32'(e.ra));
        check("count",     32'(count),     32'(e.cnt));
        check("empty",     32'(empty),     32'(e.emp));
        check("full",      32'(full),      32'(e.ful));
      end
    end
  end

  task automatic model_push(input logic [AW-1:0] v);
    model_q.push_back(v);
    if (model_q.size() > DEPTH) void'(model_q.pop_front());
  endtask

  task automatic model_update(input logic r, v, jal, jr, input logic [AW-1:0] a,
                              input logic fl, ck, rs);
    logic [AW-1:0] val;
    val = a + AW'(2);
    if (r) begin
      model_q.delete();
      snap_q.delete();
      return;
    end
`ifdef RAS_CHECKPOINT_EN
    if (rs) model_q = snap_q;
    else
`endif
    if (fl) model_q.delete();
    else if (v && jal && !jr) model_push(val);
    else if (v && jr && !jal) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
    end else if (v && jal && jr) begin
      if (model_q.size() == 0) model_push(val);
      else model_q[model_q.size()-1] = val;
    end
`ifdef RAS_CHECKPOINT_EN
    if (ck) snap_q = model_q;
`endif
  endtask

  // Drives one cycle of inputs. It records what the DUT must show during
  // this cycle, then advances the model by the effect of these inputs.
  task automatic step(input logic r, v, jal, jr, input logic [AW-1:0] a,
                      input logic fl, ck, rs);
    exp_t e;
    @(posedge clk);
    #1;
    rst_in = r; valid_in = v; jal_in = jal; jr_in = jr; addr_in = a;
    flush_in = fl; ckpt_in = ck; restore_in = rs;
    if (!r) begin
      e.rv  = (model_q.size() > 0);
      e.ra  = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
      e.cnt = (PW+1)'(model_q.size());
      e.emp = (model_q.size() == 0);
      e.ful = (model_q.size() == DEPTH);
      exp_q.push_back(e);
    end
    model_update(r, v, jal, jr, a, fl, ck, rs);
  endtask

  task automatic idle();   step(0, 0, 0, 0, '0, 0, 0, 0); endtask
  task automatic jal_at(input logic [AW-1:0] a); step(0, 1, 1, 0, a, 0, 0, 0); endtask
  task automatic jr_at(input logic [AW-1:0] a);  step(0, 1, 0, 1, a, 0, 0, 0); endtask

  initial begin
    // Reset held for two cycles, then idle.
    step(1, 0, 0, 0, '0, 0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0, 0);
    idle();
    idle();

    // Push then pop.
    jal_at(22'h000100);
    jr_at(22'h000200);
    idle();

    // Overflow: nine pushes, then nine pops (the last one underflows).
    for (int i = 1; i <= 9; i++) jal_at(AW'(16 * i));
    for (int i = 0; i < 9; i++) jr_at(22'h000300);
    idle();

    // Address wrap.
    jal_at(22'h3FFFFF);
    idle();
    jr_at(22'h000010);

    // Gating and simultaneity.
    step(0, 0, 1, 0, 22'h000050, 0, 0, 0);
    jal_at(22'h000010);
    jal_at(22'h000020);
    step(0, 1, 1, 1, 22'h000040, 0, 0, 0);
    idle();
    step(0, 1, 1, 0, 22'h000060, 1, 0, 0);
    idle();
    step(0, 1, 1, 1, 22'h000070, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, '0, 1, 0, 0);

`ifdef RAS_CHECKPOINT_EN
    // Checkpoint and restore.
    jal_at(22'h000010);
    step(0, 1, 1, 0, 22'h000020, 0, 1, 0);
    jr_at(22'h000100);
    jr_at(22'h000100);
    step(0, 0, 0, 0, '0, 0, 0, 1);
    idle();
    step(0, 0, 0, 0, '0, 1, 0, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic v, jal, jr, fl, ck, rs;
      logic [AW-1:0] a;
      v   = ($urandom_range(3) != 0);
      jal = $urandom_range(1);
      jr  = $urandom_range(1);
      a   = AW'($urandom);
      fl  = ($urandom_range(19) == 0);
`ifdef RAS_CHECKPOINT_EN
      ck = 1'b0;
      rs = 1'b0;
`else
      ck = $urandom_range(1);
      rs = $urandom_range(1);
`endif
      step(0, v, jal, jr, a, fl, ck, rs);
    end

    // Reset from a non-empty stack.
    jal_at(22'h000abc);
    step(1, 1, 1, 0, 22'h000def, 0, 0, 0);
    idle();
    idle();

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
